// File: rtl/ro_freq_meter_if.sv
// Wishbone slave bundle for the ring-oscillator frequency meter.
// The management SoC acts as master; ro_freq_meter uses the slave view.
interface ro_freq_meter_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/ro_freq_meter.sv
// Wishbone-controlled frequency meter: selects a ring oscillator, enables it,
// counts rising edges of the muxed output over a programmable window.
module ro_freq_meter #(
    parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
    parameter int          COUNT_WIDTH   = 32,
    parameter int          SETTLE_CYCLES = 16,
    parameter logic [31:0] WINDOW_RESET  = 32'd1024
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    ro_freq_meter_if.slave wbs,
    input  logic           osc_i,
    output logic [3:0]     sel_o,
    output logic           ro_start_o,
    output logic           irq_o
);

    localparam int SETTLE_W = $clog2(SETTLE_CYCLES);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_MEASURE,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [SETTLE_W-1:0]    settleCnt_q, settleCnt_d;
    logic [31:0]            windowCnt_q, windowCnt_d;
    logic [COUNT_WIDTH-1:0] edgeCnt_q, edgeCnt_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   done_q, done_d;
    logic                   ovf_q, ovf_d;

    logic                   cont_q;
    logic [3:0]             ctrlSel_q;
    logic [31:0]            window_q;

    logic                   ack_q;
    logic                   reqWe_q;
    logic [1:0]             reqOff_q;
    logic [3:0]             reqSel_q;
    logic [31:0]            reqDat_q;

    logic                   oscMeta_q, oscSync_q, oscHist_q;
    logic                   rise;

    logic                   addrMatch, hit;
    logic                   wrEn, wrCtrl, wrWindow, wrStatus;
    logic                   startCmd, abortCmd;
    logic [31:0]            readData;
    logic [31:0]            windowLoad;
    logic                   edgeFull;
    logic [COUNT_WIDTH-1:0] edgeFinal;
    logic                   unusedAdrBits;

    assign unusedAdrBits = ^wbs.wbs_adr_i[1:0];

    // osc_i is asynchronous: two flops for metastability, one more for edge history.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            oscMeta_q <= 1'b0;
            oscSync_q <= 1'b0;
            oscHist_q <= 1'b0;
        end else begin
            oscMeta_q <= osc_i;
            oscSync_q <= oscMeta_q;
            oscHist_q <= oscSync_q;
        end
    end

    assign rise = oscSync_q & ~oscHist_q;

    assign addrMatch = (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign hit       = wbs.wbs_stb_i & wbs.wbs_cyc_i & addrMatch & ~ack_q;

    // The request is captured on the hit and acted on during the ack cycle,
    // so write side effects and ack happen together.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            reqWe_q  <= 1'b0;
            reqOff_q <= 2'd0;
            reqSel_q <= 4'd0;
            reqDat_q <= 32'd0;
        end else begin
            ack_q <= hit;
            if (hit) begin
                reqWe_q  <= wbs.wbs_we_i;
                reqOff_q <= wbs.wbs_adr_i[3:2];
                reqSel_q <= wbs.wbs_sel_i;
                reqDat_q <= wbs.wbs_dat_i;
            end
        end
    end

    assign wrEn     = ack_q & reqWe_q;
    assign wrCtrl   = wrEn & (reqOff_q == 2'd0) & reqSel_q[0];
    assign wrWindow = wrEn & (reqOff_q == 2'd1);
    assign wrStatus = wrEn & (reqOff_q == 2'd3) & reqSel_q[0];
    assign startCmd = wrCtrl & reqDat_q[0];
    assign abortCmd = wrCtrl & reqDat_q[2];

    always_comb begin
        readData = 32'd0;
        case (reqOff_q)
            2'd0:    readData = {24'd0, ctrlSel_q, 2'b00, cont_q, 1'b0};
            2'd1:    readData = window_q;
            2'd2:    readData = 32'(count_q);
            default: readData = {29'd0, ovf_q, done_q, ro_start_o};
        endcase
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = ack_q ? readData : 32'd0;

    // SEL may only change while idle so a running measurement keeps its oscillator.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cont_q    <= 1'b0;
            ctrlSel_q <= 4'd0;
            window_q  <= WINDOW_RESET;
        end else begin
            if (wrCtrl) begin
                cont_q <= reqDat_q[1];
                if (state_q == S_IDLE) begin
                    ctrlSel_q <= reqDat_q[7:4];
                end
            end
            if (wrWindow) begin
                for (int b = 0; b < 4; b++) begin
                    if (reqSel_q[b]) begin
                        window_q[8*b +: 8] <= reqDat_q[8*b +: 8];
                    end
                end
            end
        end
    end

    assign windowLoad = (window_q == 32'd0) ? 32'd1 : window_q;
    assign edgeFull   = &edgeCnt_q;
    assign edgeFinal  = (rise && !edgeFull) ? edgeCnt_q + 1'b1 : edgeCnt_q;

    // Status clears are applied first so a hardware set in the same cycle wins.
    always_comb begin
        state_d     = state_q;
        settleCnt_d = settleCnt_q;
        windowCnt_d = windowCnt_q;
        edgeCnt_d   = edgeCnt_q;
        count_d     = count_q;
        done_d      = done_q;
        ovf_d       = ovf_q;

        if (wrStatus) begin
            if (reqDat_q[1]) done_d = 1'b0;
            if (reqDat_q[2]) ovf_d  = 1'b0;
        end

        if (abortCmd) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (startCmd) begin
                        state_d     = S_ARM;
                        settleCnt_d = '0;
                        done_d      = 1'b0;
                    end
                end
                S_ARM: begin
                    if (settleCnt_q == SETTLE_LAST) begin
                        state_d     = S_MEASURE;
                        windowCnt_d = windowLoad;
                        edgeCnt_d   = '0;
                    end else begin
                        settleCnt_d = settleCnt_q + 1'b1;
                    end
                end
                S_MEASURE: begin
                    if (rise) begin
                        if (edgeFull) ovf_d = 1'b1;
                        else          edgeCnt_d = edgeCnt_q + 1'b1;
                    end
                    if (windowCnt_q <= 32'd1) begin
                        state_d = S_DONE;
                    end else begin
                        windowCnt_d = windowCnt_q - 32'd1;
                    end
                end
                S_DONE: begin
                    count_d = edgeFinal;
                    done_d  = 1'b1;
                    if (rise && edgeFull) ovf_d = 1'b1;
                    if (cont_q) begin
                        state_d     = S_MEASURE;
                        windowCnt_d = windowLoad;
                        edgeCnt_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            settleCnt_q <= '0;
            windowCnt_q <= 32'd0;
            edgeCnt_q   <= '0;
            count_q     <= '0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            settleCnt_q <= settleCnt_d;
            windowCnt_q <= windowCnt_d;
            edgeCnt_q   <= edgeCnt_d;
            count_q     <= count_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
        end
    end

    assign ro_start_o = (state_q != S_IDLE);
    assign sel_o      = ctrlSel_q;
    assign irq_o      = done_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Scoreboard bench for ro_freq_meter: a default instance plus an 8-bit-counter
// instance at the next address block, sharing one Wishbone master and one oscillator.
module tb_ro_freq_meter;

    localparam logic [31:0] A_BASE = 32'h3000_0000;
    localparam logic [31:0] B_BASE = 32'h3000_0010;
    localparam logic [31:0] MISS   = 32'h3000_0020;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        stb  = 1'b0;
    logic        cyc  = 1'b0;
    logic        we   = 1'b0;
    logic [3:0]  bsel = 4'd0;
    logic [31:0] adr  = 32'd0;
    logic [31:0] wdat = 32'd0;
    logic        osc  = 1'b0;
    int          oscHalfNs = 0;
    int          cycleCnt  = 0;
    int          totalChecks = 0;
    int          passCount   = 0;

    logic [3:0]  selA, selB;
    logic        startA, startB, irqA, irqB;
    logic        ackAny;
    logic [31:0] datAny;

    string       expName[$];
    logic [31:0] expLo[$];
    logic [31:0] expHi[$];
    logic [31:0] gotQ[$];

    ro_freq_meter_if busA ();
    ro_freq_meter_if busB ();

    assign busA.wbs_stb_i = stb;
    assign busA.wbs_cyc_i = cyc;
    assign busA.wbs_we_i  = we;
    assign busA.wbs_sel_i = bsel;
    assign busA.wbs_adr_i = adr;
    assign busA.wbs_dat_i = wdat;
    assign busB.wbs_stb_i = stb;
    assign busB.wbs_cyc_i = cyc;
    assign busB.wbs_we_i  = we;
    assign busB.wbs_sel_i = bsel;
    assign busB.wbs_adr_i = adr;
    assign busB.wbs_dat_i = wdat;

    assign ackAny = busA.wbs_ack_o | busB.wbs_ack_o;
    assign datAny = busA.wbs_dat_o | busB.wbs_dat_o;

    ro_freq_meter #(.BASE_ADDR(A_BASE)) dutA (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs        (busA),
        .osc_i      (osc),
        .sel_o      (selA),
        .ro_start_o (startA),
        .irq_o      (irqA)
    );

    ro_freq_meter #(.BASE_ADDR(B_BASE), .COUNT_WIDTH(8)) dutB (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs        (busB),
        .osc_i      (osc),
        .sel_o      (selB),
        .ro_start_o (startB),
        .irq_o      (irqB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Free-running oscillator, phase-offset from the clock; half period of 0 parks it low.
    initial begin
        #3;
        forever begin
            if (oscHalfNs == 0) begin
                osc = 1'b0;
                #7;
            end else begin
                #(oscHalfNs);
                osc = ~osc;
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation still running at 300us, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic pushExp(input string name, input logic [31:0] lo, input logic [31:0] hi);
        expName.push_back(name);
        expLo.push_back(lo);
        expHi.push_back(hi);
    endtask

    task automatic wbWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        int n;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = addr; wdat = data; bsel = mask;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ackAny !== 1'b1 && n < 8);
        if (ackAny !== 1'b1) begin
            totalChecks++;
            $display("[TB] FAIL bus_write_timeout adr=%h: ack=%b, expected ack within 8 cycles", addr, ackAny);
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wbRead(input logic [31:0] addr);
        int n;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = addr; bsel = 4'hF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ackAny !== 1'b1 && n < 8);
        if (ackAny === 1'b1) begin
            gotQ.push_back(datAny);
        end else begin
            gotQ.push_back(32'hDEAD_BEEF);
            totalChecks++;
            $display("[TB] FAIL bus_read_timeout adr=%h: ack=%b, expected ack within 8 cycles", addr, ackAny);
        end
        stb = 1'b0; cyc = 1'b0;
    endtask

    task automatic waitIrq(input bit useB, input int maxCycles, output int seenAt);
        int n;
        n = 0;
        seenAt = -1;
        while (n < maxCycles) begin
            @(negedge clk);
            n++;
            if ((useB ? irqB : irqA) === 1'b1) begin
                seenAt = cycleCnt;
                break;
            end
        end
        if (seenAt < 0) begin
            totalChecks++;
            $display("[TB] FAIL irq_timeout: irq low after %0d cycles, expected it to rise", maxCycles);
        end
    endtask

    task automatic test_reset();
        int acks;
        string nm;
        logic [31:0] lo, hi, g;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        totalChecks++;
        if ({selA, startA, irqA, selB, startB, irqB} !== 12'd0)
            $display("[TB] FAIL reset_outputs: got %b, expected all zero", {selA, startA, irqA, selB, startB, irqB});
        else passCount++;
        totalChecks++;
        if (ackAny !== 1'b0 || datAny !== 32'd0)
            $display("[TB] FAIL reset_bus: ack=%b dat=%h, expected ack=0 dat=0", ackAny, datAny);
        else passCount++;
        rst = 1'b0;

        pushExp("window_reset", 32'd1024, 32'd1024); wbRead(A_BASE + 32'h4);
        pushExp("status_reset", 32'd0, 32'd0);       wbRead(A_BASE + 32'hC);
        pushExp("ctrl_reset", 32'd0, 32'd0);         wbRead(A_BASE + 32'h0);
        pushExp("count_reset", 32'd0, 32'd0);        wbRead(A_BASE + 32'h8);
        pushExp("window_reset_b", 32'd1024, 32'd1024); wbRead(B_BASE + 32'h4);
        wbWrite(A_BASE + 32'h4, 32'hFFFF_FF55, 4'b0001);
        pushExp("window_byte_lane", 32'h0000_0455, 32'h0000_0455); wbRead(A_BASE + 32'h4);
        while (expName.size() > 0) begin
            nm = expName.pop_front(); lo = expLo.pop_front(); hi = expHi.pop_front();
            g = (gotQ.size() > 0) ? gotQ.pop_front() : 32'hDEAD_BEEF;
            totalChecks++;
            if ((g >= lo && g <= hi) === 1'b1) passCount++;
            else $display("[TB] FAIL %s: got 0x%h, expected 0x%h..0x%h", nm, g, lo, hi);
        end

        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = MISS;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (ackAny === 1'b1) acks++;
        end
        stb = 1'b0; cyc = 1'b0;
        totalChecks++;
        if (acks != 0) $display("[TB] FAIL miss_no_ack: got %0d acks, expected 0", acks);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        int acks, consec;
        logic prevAck;
        logic badData;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = A_BASE + 32'h4; bsel = 4'hF;
        acks = 0; consec = 0; prevAck = 1'b0; badData = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ackAny === 1'b1) begin
                acks++;
                if (prevAck) consec++;
                if (datAny !== 32'h0000_0455) badData = 1'b1;
            end else if (datAny !== 32'd0) begin
                badData = 1'b1;
            end
            prevAck = ackAny;
        end
        stb = 1'b0; cyc = 1'b0;
        totalChecks++;
        if (acks != 3 || consec != 0)
            $display("[TB] FAIL ack_spacing: got %0d acks with %0d back-to-back, expected 3 and 0", acks, consec);
        else passCount++;
        totalChecks++;
        if (badData) $display("[TB] FAIL dat_gating: read data wrong or nonzero outside ack, expected 0x455 only on ack");
        else passCount++;
    endtask

    task automatic test_basic_and_busy();
        int ackCycle, irqCycle;
        string nm;
        logic [31:0] lo, hi, g;
        oscHalfNs = 50;
        wbWrite(A_BASE + 32'h4, 32'd1000, 4'hF);
        wbWrite(A_BASE + 32'h0, 32'h0000_0051, 4'hF);
        ackCycle = cycleCnt;
        totalChecks++;
        if (startA !== 1'b0) $display("[TB] FAIL start_in_ack_cycle: got %b, expected 0", startA);
        else passCount++;
        @(negedge clk);
        totalChecks++;
        if (startA !== 1'b1 || selA !== 4'd5)
            $display("[TB] FAIL start_rise: ro_start=%b sel=%0d, expected 1 and 5", startA, selA);
        else passCount++;
        pushExp("status_busy", 32'h1, 32'h1); wbRead(A_BASE + 32'hC);

        repeat (200) @(negedge clk);
        wbWrite(A_BASE + 32'h0, 32'h0000_0091, 4'hF);
        @(negedge clk);
        totalChecks++;
        if (selA !== 4'd5) $display("[TB] FAIL sel_locked_busy: got %0d, expected 5", selA);
        else passCount++;

        waitIrq(1'b0, 1100, irqCycle);
        totalChecks++;
        if (irqCycle - ackCycle < 1016 || irqCycle - ackCycle > 1020)
            $display("[TB] FAIL window_not_restarted: irq %0d cycles after start ack, expected 1016..1020", irqCycle - ackCycle);
        else passCount++;
        @(negedge clk);
        totalChecks++;
        if (startA !== 1'b0) $display("[TB] FAIL start_low_after: got %b, expected 0", startA);
        else passCount++;
        pushExp("count_basic", 32'd99, 32'd101); wbRead(A_BASE + 32'h8);
        pushExp("status_done", 32'h2, 32'h2);    wbRead(A_BASE + 32'hC);
        wbWrite(A_BASE + 32'hC, 32'h2, 4'hF);
        @(negedge clk);
        totalChecks++;
        if (irqA !== 1'b0) $display("[TB] FAIL irq_w1c: got %b, expected 0", irqA);
        else passCount++;
        pushExp("status_cleared", 32'h0, 32'h0); wbRead(A_BASE + 32'hC);
        while (expName.size() > 0) begin
            nm = expName.pop_front(); lo = expLo.pop_front(); hi = expHi.pop_front();
            g = (gotQ.size() > 0) ? gotQ.pop_front() : 32'hDEAD_BEEF;
            totalChecks++;
            if ((g >= lo && g <= hi) === 1'b1) passCount++;
            else $display("[TB] FAIL %s: got 0x%h, expected 0x%h..0x%h", nm, g, lo, hi);
        end
    endtask

    task automatic test_overflow();
        int irqCycle;
        string nm;
        logic [31:0] lo, hi, g;
        oscHalfNs = 20;
        wbWrite(B_BASE + 32'h4, 32'd2000, 4'hF);
        wbWrite(B_BASE + 32'h0, 32'h0000_0001, 4'hF);
        waitIrq(1'b1, 2200, irqCycle);
        pushExp("count_saturated", 32'd255, 32'd255); wbRead(B_BASE + 32'h8);
        pushExp("status_ovf_done", 32'h6, 32'h6);     wbRead(B_BASE + 32'hC);
        wbWrite(B_BASE + 32'hC, 32'h6, 4'hF);
        pushExp("status_ovf_cleared", 32'h0, 32'h0);  wbRead(B_BASE + 32'hC);
        while (expName.size() > 0) begin
            nm = expName.pop_front(); lo = expLo.pop_front(); hi = expHi.pop_front();
            g = (gotQ.size() > 0) ? gotQ.pop_front() : 32'hDEAD_BEEF;
            totalChecks++;
            if ((g >= lo && g <= hi) === 1'b1) passCount++;
            else $display("[TB] FAIL %s: got 0x%h, expected 0x%h..0x%h", nm, g, lo, hi);
        end
    endtask

    task automatic test_continuous();
        int t1, t2, t3;
        string nm;
        logic [31:0] lo, hi, g;
        oscHalfNs = 25;
        wbWrite(A_BASE + 32'h4, 32'd50, 4'hF);
        wbWrite(A_BASE + 32'h0, 32'h0000_0053, 4'hF);
        waitIrq(1'b0, 200, t1);
        wbWrite(A_BASE + 32'hC, 32'h2, 4'hF);
        waitIrq(1'b0, 100, t2);
        totalChecks++;
        if (t2 - t1 != 51) $display("[TB] FAIL cont_period_1: got %0d cycles, expected 51", t2 - t1);
        else passCount++;
        totalChecks++;
        if (startA !== 1'b1) $display("[TB] FAIL cont_start_held: got %b, expected 1", startA);
        else passCount++;
        pushExp("count_cont_1", 32'd9, 32'd11); wbRead(A_BASE + 32'h8);
        wbWrite(A_BASE + 32'hC, 32'h2, 4'hF);
        waitIrq(1'b0, 100, t3);
        totalChecks++;
        if (t3 - t2 != 51) $display("[TB] FAIL cont_period_2: got %0d cycles, expected 51", t3 - t2);
        else passCount++;
        pushExp("count_cont_2", 32'd9, 32'd11); wbRead(A_BASE + 32'h8);
        pushExp("ctrl_readback", 32'h52, 32'h52); wbRead(A_BASE + 32'h0);
        wbWrite(A_BASE + 32'h0, 32'h0000_0004, 4'hF);
        @(negedge clk);
        totalChecks++;
        if (startA !== 1'b0) $display("[TB] FAIL cont_abort: ro_start=%b, expected 0", startA);
        else passCount++;
        wbWrite(A_BASE + 32'hC, 32'h6, 4'hF);
        while (expName.size() > 0) begin
            nm = expName.pop_front(); lo = expLo.pop_front(); hi = expHi.pop_front();
            g = (gotQ.size() > 0) ? gotQ.pop_front() : 32'hDEAD_BEEF;
            totalChecks++;
            if ((g >= lo && g <= hi) === 1'b1) passCount++;
            else $display("[TB] FAIL %s: got 0x%h, expected 0x%h..0x%h", nm, g, lo, hi);
        end
    endtask

    task automatic test_abort_and_reset();
        string nm;
        logic [31:0] lo, hi, g;
        oscHalfNs = 50;
        wbWrite(A_BASE + 32'h4, 32'd1000, 4'hF);
        wbWrite(A_BASE + 32'h0, 32'h0000_0001, 4'hF);
        @(negedge clk);
        wbWrite(A_BASE + 32'h0, 32'h0000_0004, 4'hF);
        totalChecks++;
        if (startA !== 1'b1) $display("[TB] FAIL arm_before_abort: ro_start=%b, expected 1", startA);
        else passCount++;
        @(negedge clk);
        totalChecks++;
        if (startA !== 1'b0 || irqA !== 1'b0)
            $display("[TB] FAIL abort_in_arm: ro_start=%b irq=%b, expected 0 and 0", startA, irqA);
        else passCount++;
        pushExp("status_after_abort", 32'h0, 32'h0); wbRead(A_BASE + 32'hC);

        wbWrite(A_BASE + 32'h0, 32'h0000_0031, 4'hF);
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        totalChecks++;
        if ({selA, startA, irqA} !== 6'd0 || ackAny !== 1'b0 || datAny !== 32'd0)
            $display("[TB] FAIL reset_mid_measure: sel=%0d start=%b irq=%b ack=%b dat=%h, expected all 0",
                     selA, startA, irqA, ackAny, datAny);
        else passCount++;
        rst = 1'b0;
        pushExp("window_after_reset", 32'd1024, 32'd1024); wbRead(A_BASE + 32'h4);
        pushExp("ctrl_after_reset", 32'd0, 32'd0);         wbRead(A_BASE + 32'h0);
        pushExp("count_after_reset", 32'd0, 32'd0);        wbRead(A_BASE + 32'h8);
        pushExp("status_after_reset", 32'd0, 32'd0);       wbRead(A_BASE + 32'hC);
        while (expName.size() > 0) begin
            nm = expName.pop_front(); lo = expLo.pop_front(); hi = expHi.pop_front();
            g = (gotQ.size() > 0) ? gotQ.pop_front() : 32'hDEAD_BEEF;
            totalChecks++;
            if ((g >= lo && g <= hi) === 1'b1) passCount++;
            else $display("[TB] FAIL %s: got 0x%h, expected 0x%h..0x%h", nm, g, lo, hi);
        end
    endtask

    initial begin
        $display("[TB] ro_freq_meter bench starting");
        test_reset();
        test_back_to_back();
        test_basic_and_busy();
        test_overflow();
        test_continuous();
        test_abort_and_reset();
        $display("%0d/%0d checks passed", passCount, totalChecks);
        $finish;
    end

endmodule

// File: doc/ro_freq_meter.md
# ro_freq_meter

Wishbone-controlled frequency meter that closes the loop on the ring-oscillator array. It drives the 4-bit oscillator select and the shared oscillator start line, counts rising edges of the selected muxed oscillator output over a programmable window of `wb_clk_i` cycles, and latches the result for firmware. It sits in `user_project_wrapper` between the management-SoC Wishbone bus and the mux16x1 output, so each oscillator can be characterized on-chip without an external counter.

## Interface
**Parameters**
- `BASE_ADDR`, default 32'h3000_0000: Wishbone base address, decoded on `wbs_adr_i[31:4]`.
- `COUNT_WIDTH`, default 32, legal range 8–32: width of the edge counter and COUNT register.
- `SETTLE_CYCLES`, default 16, must be ≥ 2: cycles between asserting `ro_start_o` and opening the window.
- `WINDOW_RESET`, default 1024: reset value of WINDOW.

**Ports**
- `wb_clk_i` in 1: the only clock.
- `wb_rst_i` in 1: reset, synchronous, active-high.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1 each: Wishbone strobe, cycle, and write enable.
- `wbs_sel_i` in 4: byte lane enables.
- `wbs_adr_i` in 32: byte address.
- `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: single-cycle acknowledge.
- `wbs_dat_o` out 32: read data.
- `osc_i` in 1: muxed oscillator output, asynchronous to `wb_clk_i`.
- `sel_o` out 4: oscillator select, to the mux `select`.
- `ro_start_o` out 1: oscillator enable, to the ring-oscillator `start` input.
- `irq_o` out 1: level interrupt, equal to STATUS.done.

## Operation
**Registers** (offset = `adr[3:2]`; writes honor `wbs_sel_i` per byte)
- 0x0 CTRL, R/W:
  - bit0 START: write 1 to start; self-clearing; reads 0.
  - bit1 CONT: continuous mode.
  - bit2 ABORT: write 1 to abort; self-clearing; reads 0.
  - bits[7:4] SEL: oscillator select.
- 0x4 WINDOW, R/W, 32 bits: measurement window in clock cycles. A value of 0 is treated as 1.
- 0x8 COUNT, RO: last latched edge count, zero-extended to 32 bits.
- 0xC STATUS:
  - bit0 BUSY, RO.
  - bit1 DONE: sticky; write 1 to clear.
  - bit2 OVF: sticky; write 1 to clear.

**Input path**
- `osc_i` → 2-flop synchronizer → 1 history flop.
- `rise` = synchronized signal high AND history flop low.

**FSM**
- IDLE: `ro_start_o`=0. START=1 → ARM and clear DONE. Writes to SEL are accepted only in IDLE and ignored otherwise.
- ARM: `ro_start_o`=1. A settle counter runs for SETTLE_CYCLES cycles, then → MEASURE. On that transition the window counter loads max(WINDOW,1) and the edge counter clears.
- MEASURE:
  - Each cycle the window counter decrements.
  - Each `rise` increments the edge counter. At all-ones the counter saturates and sets OVF.
  - When the window counter reaches 1 → DONE.
- DONE (one cycle):
  - Latch COUNT, including a `rise` in this final cycle; set DONE.
  - If CONT=1 → MEASURE: reload the window, clear the edge counter, keep `ro_start_o` high.
  - If CONT=0 → IDLE.
- ABORT=1 in any state → IDLE. DONE and COUNT are unchanged; OVF is unchanged.
- START while BUSY: ignored.
- BUSY = state ≠ IDLE.
- Simultaneous events:
  - DONE set by hardware and W1C in the same cycle: the set wins.
  - Same rule for OVF.

**Wishbone**
- Address hit: `stb & cyc` and `adr[31:4] == BASE_ADDR[31:4]`.
- `wbs_ack_o` pulses for exactly one cycle, the cycle after a hit.
- No ack is generated on a miss; another slave answers.
- `wbs_ack_o` is never asserted on two consecutive cycles.
- Write side effects occur in the cycle after the hit, together with `ack`.
- `wbs_dat_o` is valid only while `ack`=1 and reads 0 otherwise.

## Timing
- Reset values:
  - `wbs_ack_o`=0, `wbs_dat_o`=0, `sel_o`=0, `ro_start_o`=0, `irq_o`=0.
  - State IDLE; COUNT=0; STATUS=0; CTRL=0; WINDOW=WINDOW_RESET.
- Reset asserted mid-measurement: all values above are restored on the next clock edge, and `ro_start_o` drops in that cycle.
- `ro_start_o` rises 1 cycle after the START write is acked. MEASURE begins SETTLE_CYCLES cycles later and lasts max(WINDOW,1) cycles.
- DONE and `irq_o` rise 1 cycle after the window closes.
- `sel_o` is registered directly from CTRL.SEL.
- Measurement limits:
  - The measurable input must stay below f_clk/2 and have a high or low phase ≥ 1 clock period.
  - Accuracy is ±1 edge, due to the 2-cycle synchronizer skew on both window edges.

## Test plan
- **Reset and readback:** pulse reset → all outputs 0. Read WINDOW = 1024 and STATUS = 0. Access with `adr` outside BASE_ADDR → no ack.
- **Basic measurement:** `osc_i` period 10 clocks, WINDOW = 1000, CTRL = SEL 5 + START. Required: `sel_o` = 5; `ro_start_o` high; DONE = 1, `irq_o` = 1, COUNT = 100 ±1; `ro_start_o` low afterwards.
- **Writes while busy:** during MEASURE, write SEL = 9 and START → `sel_o` stays 5 and the window is not restarted. After DONE, W1C DONE → `irq_o` = 0.
- **Overflow:** build with COUNT_WIDTH = 8; `osc_i` period 4, WINDOW = 2000 → COUNT = 255, OVF = 1.
- **Continuous mode:** CONT = 1 + START, WINDOW = 50, `osc_i` period 5 → COUNT updates to 10 ±1 every 51 cycles with `ro_start_o` held high.
- **Abort and reset mid-run:** ABORT during ARM → IDLE next cycle, `ro_start_o` = 0, DONE = 0. Reset asserted mid-MEASURE → all outputs at their reset values the next cycle.
